// File: rtl/prog_sequencer.sv
// Run-control sequencer: owns the program counter, the start/done handshake,
// commit gating for register/memory writes and load wait-state stretching.
module prog_sequencer #(
  parameter int PC_W      = 10,
  parameter int LOAD_WAIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  pc,
  output logic             commit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_BNE  = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] LW = 3'(LOAD_WAIT);

  logic [1:0]       state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [2:0]       stall_reg, stall_next;
  logic             done_reg, done_next;
  logic [3:0]       opcode;
  logic [4:0]       instr_unused;

  assign opcode       = instr[8:5];
  assign instr_unused = instr[4:0];

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    commit = 1'b0;
    case (state_reg)
      S_RUN:   commit = (opcode != OP_HALT) && ((opcode != OP_LOAD) || (LW == 3'd0));
      S_LWAIT: commit = (stall_reg == 3'd1);
      default: commit = 1'b0;
    endcase
  end

  assign busy = (state_reg == S_RUN) || (state_reg == S_LWAIT);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    stall_next = stall_reg;
    done_next  = done_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          pc_next    = '0;
          cnt_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        cnt_next = cnt_inc;
        if (opcode == OP_HALT) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else if ((opcode == OP_LOAD) && (LW != 3'd0)) begin
          stall_next = LW;
          state_next = S_LWAIT;
        end else if ((opcode == OP_BNE) && br_taken) begin
          pc_next = br_target;
        end else begin
          pc_next = pc_reg + PC_W'(1);
        end
      end
      S_LWAIT: begin
        cnt_next = cnt_inc;
        if (stall_reg > 3'd1) begin
          stall_next = stall_reg - 3'd1;
        end else begin
          stall_next = 3'd0;
          pc_next    = pc_reg + PC_W'(1);
          state_next = S_RUN;
        end
      end
      default: begin
        if (start) begin
          done_next  = 1'b0;
          pc_next    = '0;
          cnt_next   = '0;
          state_next = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      stall_reg <= 3'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      stall_reg <= stall_next;
      done_reg  <= done_next;
    end
  end

  assign pc          = pc_reg;
  assign done        = done_reg;
  assign cycle_count = cnt_reg;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus random
// programs, checked cycle by cycle against an instruction-level model.
module tb_prog_sequencer;
  localparam int LW = 2;
  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic        clk = 1'b0;
  logic        reset, start, br_taken;
  logic [8:0]  instr;
  logic [9:0]  br_target, pc;
  logic        commit, busy, done;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  logic [8:0] rom [1024];
  logic [9:0] tgt [1024];
  bit         bq [$];

  always #5 clk = ~clk;

  assign instr     = rom[pc];
  assign br_target = tgt[pc];

  prog_sequencer #(.PC_W(10), .LOAD_WAIT(LW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .br_taken(br_taken), .br_target(br_target), .pc(pc),
    .commit(commit), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op);
    return {op, 5'($urandom)};
  endfunction

  function automatic int sat(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = mk(OP_ADD);
      tgt[i] = 10'($urandom);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_commit"}, commit, 0);
    chk({tag, "_count"}, cycle_count, 0);
  endtask

  // Instruction-level model: each instruction lasts 1 cycle (1+LW for a load),
  // commits on its last cycle unless it is a halt, then picks the next pc.
  task automatic run_prog(input int max_instr);
    int ref_pc = 0;
    int n = 0;
    bit halted = 0;
    logic [3:0] op;
    bit tk;
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < max_instr && !halted; i++) begin
      op  = rom[ref_pc][8:5];
      tk  = (bq.size() > 0) ? bq.pop_front() : bit'($urandom % 2);
      br_taken = tk;
      cyc = (op == OP_LOAD) ? 1 + LW : 1;
      for (int k = 0; k < cyc; k++) begin
        chk("run_pc", pc, ref_pc);
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_commit", commit, (op != OP_HALT) && (k == cyc - 1));
        chk("run_count", cycle_count, sat(n));
        start = 1'($urandom % 2);
        @(negedge clk);
        n++;
      end
      if (op == OP_HALT) halted = 1;
      else if (op == OP_BNE && tk) ref_pc = int'(tgt[ref_pc]);
      else ref_pc = (ref_pc + 1) % 1024;
    end
    start = 1'b0;
    chk("halt_reached", halted, 1);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_commit", commit, 0);
    chk("end_pc", pc, ref_pc);
    chk("end_count", cycle_count, sat(n));
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_pc", pc, ref_pc);
    chk("hold_count", cycle_count, sat(n));
  endtask

  initial begin
    int len;
    logic [3:0] op;
    reset = 1'b1;
    start = 1'b1;
    br_taken = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    check_idle("rst_hold");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("rst_rel");
    @(negedge clk);
    check_idle("rst_idle");

    clear_rom();
    rom[0] = mk(OP_ADD); rom[1] = mk(OP_XOR); rom[2] = mk(OP_HALT);
    run_prog(10);
    chk("progA_count", cycle_count, 3);
    chk("progA_pc", pc, 2);
    run_prog(10);
    chk("progA2_count", cycle_count, 3);

    clear_rom();
    rom[0] = mk(OP_LOAD); rom[1] = mk(OP_HALT);
    run_prog(10);
    chk("load_count", cycle_count, 4);
    chk("load_pc", pc, 1);

    clear_rom();
    rom[5] = mk(OP_BNE); tgt[5] = 10'd40;
    rom[40] = mk(OP_HALT); rom[6] = mk(OP_HALT);
    bq = '{};
    for (int i = 0; i < 5; i++) bq.push_back(1'b0);
    bq.push_back(1'b1);
    run_prog(20);
    chk("bne_taken_pc", pc, 40);
    for (int i = 0; i < 5; i++) bq.push_back(1'b1);
    bq.push_back(1'b0);
    run_prog(20);
    chk("bne_fall_pc", pc, 6);

    clear_rom();
    rom[0] = mk(OP_BNE); tgt[0] = 10'd1023;
    rom[1023] = mk(OP_ADD); rom[1] = mk(OP_HALT);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b0);
    run_prog(10);
    chk("wrap_pc", pc, 1);
    chk("wrap_count", cycle_count, 4);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("done_rst");

    // Reset lands on the final wait cycle, where commit would otherwise fire.
    clear_rom();
    rom[0] = mk(OP_LOAD); rom[1] = mk(OP_HALT);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LW) @(negedge clk);
    chk("lwait_busy", busy, 1);
    chk("lwait_commit", commit, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("lwait_rst");
    @(negedge clk);
    check_idle("lwait_idle");

    for (int p = 0; p < 12; p++) begin
      clear_rom();
      len = $urandom_range(3, 30);
      for (int a = 0; a < len; a++) begin
        case ($urandom % 6)
          0: op = OP_LOAD;
          1: op = OP_BNE;
          2: op = OP_ADD;
          3: op = OP_XOR;
          default: op = 4'($urandom_range(4, 14));
        endcase
        rom[a] = mk(op);
        if (op == OP_BNE) tgt[a] = 10'($urandom_range(a + 1, len));
      end
      rom[len] = mk(OP_HALT);
      run_prog(200);
    end

    clear_rom();
    rom[0] = mk(OP_BNE); tgt[0] = 10'd0; rom[1] = mk(OP_HALT);
    for (int i = 0; i < 66000; i++) bq.push_back(1'b1);
    bq.push_back(1'b0);
    run_prog(70000);
    chk("sat_count", cycle_count, 65535);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run-control sequencer for the 9-bit single-issue core. It owns the program counter and the start/done handshake with the test harness.
- Gates datapath commits, which are the register-file and data-memory write enables that the control decoder produces.
- Stretches loads over extra wait cycles for the data memory.
- Sits between the instruction ROM (combinational read at pc) and the control decoder / ALU. Consumes the branch compare result and the branch target lookup.

Parameters:
- PC_W, 10, program counter width (1024-entry instruction ROM)
- LOAD_WAIT, 1, extra stall cycles per load (0..7)
- CNT_W, 16, width of the executed-cycle counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  harness request to run program from address 0
- instr  input  9  current instruction from ROM at pc; opcode is instr[8:5]
- br_taken  input  1  ALU compare result for bne, valid in the instruction's cycle
- br_target  input  PC_W  absolute branch target from the lookup table
- pc  output  PC_W  current program counter
- commit  output  1  the current instruction retires this cycle; AND into RegWrite/MemWrite
- busy  output  1  high in RUN or LWAIT
- done  output  1  program finished; held until next start or reset
- cycle_count  output  CNT_W  clock cycles spent in RUN+LWAIT since last start

Behaviour:
- Reset, as an outcome:
  - state IDLE, pc=0, commit=0, busy=0, done=0, cycle_count=0, stall counter=0.
  - Reset has priority over every other input.
- Reset asserted mid-run: the next cycle is IDLE with the values above. No commit is asserted in that cycle.
- States: IDLE, RUN, LWAIT, DONE.
- IDLE:
  - commit=0.
  - start=1: pc<=0, cycle_count<=0, go to RUN.
- RUN, instruction decoded from instr[8:5]:
  - 4'b1111 (halt): commit=0, pc holds, go to DONE. done=1 from the next cycle.
  - 4'b0000 (load):
    - If LOAD_WAIT=0: commit=1 and pc<=pc+1 this cycle.
    - Otherwise: commit=0, stall counter<=LOAD_WAIT, go to LWAIT, pc holds.
  - 4'b0011 (bne): commit=1. If br_taken then pc<=br_target, else pc<=pc+1.
  - All other opcodes: commit=1, pc<=pc+1.
- LWAIT:
  - commit=0 while stall counter>1; counter decrements each cycle.
  - When counter==1: commit=1, pc<=pc+1, return to RUN.
  - A load therefore occupies exactly 1+LOAD_WAIT cycles and commits once, on its last cycle.
  - instr must remain stable, since pc holds.
- DONE:
  - done=1, busy=0, commit=0. pc and cycle_count hold for inspection.
  - start=1: done<=0, pc<=0, cycle_count<=0, go to RUN.
- start in RUN or LWAIT is ignored.
- A start pulse and a halt in the same cycle: halt wins, then the sequencer waits in DONE for a new start.
- cycle_count:
  - Increments by 1 on every cycle spent in RUN or LWAIT, including the halt cycle.
  - Saturates at all-ones and does not wrap.
- pc arithmetic:
  - pc+1 is modulo 2^PC_W; from 2^PC_W-1 it wraps to 0. This is not an error.
  - br_target is used as-is, with no relative offset.
- Outputs commit and busy are combinational from the registered state and instr; all other outputs are registered.
- No commit is ever asserted in IDLE or DONE.

Test Plan:
- Reset during any state, then release with start=0 -> pc=0, done=0, busy=0, commit=0, cycle_count=0, staying in IDLE.
- ROM: 0:add, 1:xor, 2:halt; pulse start -> commit high for 2 cycles with pc 0,1. pc holds at 2, done=1 one cycle after the halt, cycle_count=3.
- LOAD_WAIT=2, ROM: 0:load, 1:halt -> pc stays 0 for 3 cycles with commit pattern 0,0,1. Then pc=1, done rises, cycle_count=4.
- ROM 5:bne with br_target=40: br_taken=1 -> next pc=40 with commit=1. br_taken=0 -> next pc=6.
- Force pc to 1023 with a non-branch instruction -> next pc=0. Also assert start mid-run -> no effect on pc or cycle_count.
- Halt, then in DONE pulse start -> done falls next cycle, pc=0, cycle_count=0, run repeats identically. Assert reset while in LWAIT -> IDLE with no commit issued.
